// File: rtl/product_accumulator_if.sv
// Valid/ready bus pair for product_accumulator: product stream in, Q15 result out.
// The slave modport is the accumulator side; the master modport is its environment.
interface product_accumulator_if;
    logic signed [31:0] P;
    logic               p_valid;
    logic               p_ready;
    logic signed [15:0] Y;
    logic               y_sat;
    logic               y_valid;
    logic               y_ready;

    modport slave (
        input  P,
        input  p_valid,
        output p_ready,
        output Y,
        output y_sat,
        output y_valid,
        input  y_ready
    );

    modport master (
        output P,
        output p_valid,
        input  p_ready,
        input  Y,
        input  y_sat,
        input  y_valid,
        output y_ready
    );
endinterface

// File: rtl/product_accumulator.sv
// Sums N_TAPS signed 32-bit products per frame and emits one saturated Q15 result.
// Optional round-half-up before the output shift: define PRODUCT_ACC_ROUND_EN.
module product_accumulator #(
    parameter int N_TAPS    = 8,
    parameter int ACC_W     = 40,
    parameter int OUT_SHIFT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    product_accumulator_if.slave bus
);

    localparam int CNT_W = (N_TAPS > 2) ? $clog2(N_TAPS) : 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_TAPS - 1);
    localparam logic signed [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};
    localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-15){1'b0}}, 16'h7FFF};
    localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W-15){1'b1}}, 16'h8000};
`ifdef PRODUCT_ACC_ROUND_EN
    localparam logic signed [ACC_W:0] RND_BIAS = {{ACC_W{1'b0}}, 1'b1} << (OUT_SHIFT - 1);
`endif

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_OUT   = 1'b1
    } state_t;

    state_t                   state_r;
    logic [CNT_W-1:0]         count_r;
    logic signed [ACC_W-1:0]  acc_r;
    logic [15:0]              y_r;
    logic                     y_sat_r;
    logic                     y_valid_r;

    logic signed [ACC_W-1:0]  p_ext_s;
    logic signed [ACC_W-1:0]  base_s;
    logic signed [ACC_W-1:0]  sum_s;
    logic signed [ACC_W:0]    wide_s;
    logic signed [ACC_W:0]    shifted_s;
    logic [16:0]              sat_res_s;

    // Clip to the signed 16-bit range; MSB of the result flags clipping.
    function automatic logic [16:0] sat16(input logic signed [ACC_W:0] v);
        logic [16:0] r;
        if (v > SAT_MAX) begin
            r = {1'b1, 16'h7FFF};
        end else if (v < SAT_MIN) begin
            r = {1'b1, 16'h8000};
        end else begin
            r = {1'b0, v[15:0]};
        end
        return r;
    endfunction

    // Running sum including the presented product, and its scaled/saturated form.
    always_comb begin
        p_ext_s = {{(ACC_W-32){bus.P[31]}}, bus.P};
        if (count_r == CNT_ZERO) begin
            base_s = ACC_ZERO;
        end else begin
            base_s = acc_r;
        end
        sum_s = base_s + p_ext_s;
`ifdef PRODUCT_ACC_ROUND_EN
        wide_s = {sum_s[ACC_W-1], sum_s} + RND_BIAS;
`else
        wide_s = {sum_s[ACC_W-1], sum_s};
`endif
        shifted_s = wide_s >>> OUT_SHIFT;
        sat_res_s = sat16(shifted_s);
    end

    // Frame FSM: accumulate products, then hold the result until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_ACCUM;
            count_r   <= CNT_ZERO;
            acc_r     <= ACC_ZERO;
            y_r       <= 16'h0000;
            y_sat_r   <= 1'b0;
            y_valid_r <= 1'b0;
        end else if (clr) begin
            // Abort wins over any accept or result handshake in the same cycle.
            state_r   <= ST_ACCUM;
            count_r   <= CNT_ZERO;
            acc_r     <= ACC_ZERO;
            y_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_ACCUM: begin
                    if (bus.p_valid) begin
                        if (count_r == LAST_IDX) begin
                            y_r       <= sat_res_s[15:0];
                            y_sat_r   <= sat_res_s[16];
                            y_valid_r <= 1'b1;
                            count_r   <= CNT_ZERO;
                            acc_r     <= ACC_ZERO;
                            state_r   <= ST_OUT;
                        end else begin
                            acc_r   <= sum_s;
                            count_r <= count_r + CNT_ONE;
                        end
                    end else begin
                        acc_r <= acc_r;
                    end
                end
                ST_OUT: begin
                    if (bus.y_ready) begin
                        y_valid_r <= 1'b0;
                        state_r   <= ST_ACCUM;
                    end else begin
                        y_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_ACCUM;
                    count_r   <= CNT_ZERO;
                    acc_r     <= ACC_ZERO;
                    y_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // p_ready decodes state only; held low while reset is asserted.
    assign bus.p_ready = rst_n & (state_r == ST_ACCUM);
    assign bus.Y       = y_r;
    assign bus.y_sat   = y_sat_r;
    assign bus.y_valid = y_valid_r;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed self-checking bench for product_accumulator (N_TAPS=4, OUT_SHIFT=15).
module tb_product_accumulator;

    localparam logic [31:0] P_HALF  = 32'd16384;
    localparam logic [31:0] P_NHALF = 32'hFFFF_C000;
    localparam logic [31:0] P_MAXP  = 32'd1073741824;
    localparam logic [31:0] P_SQ    = 32'd1073676289;
    localparam logic [31:0] P_NEGP  = 32'hC000_8000;
    localparam logic [31:0] P_2400  = 32'd2400;
`ifdef PRODUCT_ACC_ROUND_EN
    localparam logic [15:0] EXP_POS = 16'h0001;
    localparam logic [15:0] EXP_NEG = 16'h0000;
`else
    localparam logic [15:0] EXP_POS = 16'h0000;
    localparam logic [15:0] EXP_NEG = 16'hFFFF;
`endif

    logic clk;
    logic rst_n;
    logic clr;
    int   checks;
    int   failures;

    product_accumulator_if bus ();

    product_accumulator #(
        .N_TAPS   (4),
        .ACC_W    (40),
        .OUT_SHIFT(15)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one product from a negedge; returns at the negedge after its accept.
    task automatic push(input logic [31:0] v, output bit ok);
        int n;
        n = 0;
        bus.P = v;
        bus.p_valid = 1'b1;
        while (bus.p_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = (bus.p_ready === 1'b1);
        @(negedge clk);
        bus.p_valid = 1'b0;
    endtask

    // Four back-to-back products, capture the result the cycle after, then take it.
    task automatic run_frame(input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] c, input logic [31:0] d,
                             output logic [15:0] y, output logic s,
                             output logic v, output bit ok);
        bit k;
        ok = 1'b1;
        push(a, k); ok &= k;
        push(b, k); ok &= k;
        push(c, k); ok &= k;
        push(d, k); ok &= k;
        v = bus.y_valid;
        y = bus.Y;
        s = bus.y_sat;
        bus.y_ready = 1'b1;
        @(negedge clk);
        bus.y_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.Y, bus.y_sat, bus.y_valid, bus.p_ready} !== 19'h0) begin
            failures++;
            $display("FAIL reset_outputs: got Y=%0d sat=%b v=%b rdy=%b want all 0",
                     $signed(bus.Y), bus.y_sat, bus.y_valid, bus.p_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.p_ready !== 1'b1 || bus.y_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got rdy=%b v=%b want rdy=1 v=0", bus.p_ready, bus.y_valid);
        end
    endtask

    task automatic test_rounding();
        logic [15:0] y; logic s; logic v; bit ok;
        run_frame(P_HALF, 32'd0, 32'd0, 32'd0, y, s, v, ok);
        checks++;
        if (!ok || v !== 1'b1) begin
            failures++;
            $display("FAIL round_pos_latency: got ok=%b y_valid=%b want 1 1", ok, v);
        end
        checks++;
        if (y !== EXP_POS || s !== 1'b0) begin
            failures++;
            $display("FAIL round_pos_y: got %0d sat=%b want %0d sat=0", $signed(y), s, $signed(EXP_POS));
        end
        checks++;
        if (bus.y_valid !== 1'b0) begin
            failures++;
            $display("FAIL result_taken: got y_valid=%b want 0", bus.y_valid);
        end
        run_frame(P_NHALF, 32'd0, 32'd0, 32'd0, y, s, v, ok);
        checks++;
        if (!ok || v !== 1'b1 || y !== EXP_NEG || s !== 1'b0) begin
            failures++;
            $display("FAIL round_neg_y: got %0d sat=%b v=%b want %0d sat=0 v=1",
                     $signed(y), s, v, $signed(EXP_NEG));
        end
    endtask

    task automatic test_saturation();
        logic [15:0] y; logic s; logic v; bit ok;
        run_frame(P_MAXP, P_MAXP, P_MAXP, P_MAXP, y, s, v, ok);
        checks++;
        if (!ok || v !== 1'b1 || y !== 16'h7FFF || s !== 1'b1) begin
            failures++;
            $display("FAIL sat_pos: got %0d sat=%b v=%b want 32767 sat=1 v=1", $signed(y), s, v);
        end
        run_frame(P_SQ, 32'd0, 32'd0, 32'd0, y, s, v, ok);
        checks++;
        if (!ok || v !== 1'b1 || y !== 16'h7FFE || s !== 1'b0) begin
            failures++;
            $display("FAIL mixed_sq: got %0d sat=%b v=%b want 32766 sat=0 v=1", $signed(y), s, v);
        end
        run_frame(P_NEGP, P_NEGP, P_NEGP, P_NEGP, y, s, v, ok);
        checks++;
        if (!ok || v !== 1'b1 || y !== 16'h8000 || s !== 1'b1) begin
            failures++;
            $display("FAIL sat_neg: got %0d sat=%b v=%b want -32768 sat=1 v=1", $signed(y), s, v);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] y; logic s; logic v; bit ok; bit k;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(P_MAXP, k);
            ok &= k;
        end
        bus.P = 32'd123;
        bus.p_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (!ok || {bus.y_valid, bus.p_ready, bus.y_sat, bus.Y} !== {3'b101, 16'h7FFF}) begin
                failures++;
                $display("FAIL stall_hold[%0d]: got v=%b rdy=%b sat=%b Y=%0d want v=1 rdy=0 sat=1 Y=32767",
                         i, bus.y_valid, bus.p_ready, bus.y_sat, $signed(bus.Y));
            end
            @(negedge clk);
        end
        bus.p_valid = 1'b0;
        bus.y_ready = 1'b1;
        @(negedge clk);
        bus.y_ready = 1'b0;
        checks++;
        if (bus.p_ready !== 1'b1 || bus.y_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_release: got rdy=%b v=%b want rdy=1 v=0", bus.p_ready, bus.y_valid);
        end
        run_frame(P_2400, P_2400, P_2400, P_2400, y, s, v, ok);
        checks++;
        if (!ok || v !== 1'b1 || y !== 16'h0000 || s !== 1'b0) begin
            failures++;
            $display("FAIL second_frame: got %0d sat=%b v=%b want 0 sat=0 v=1", $signed(y), s, v);
        end
    endtask

    task automatic test_clr();
        logic [15:0] y; logic s; logic v; bit ok; bit k;
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(P_MAXP, k);
            ok &= k;
        end
        bus.P = P_MAXP;
        bus.p_valid = 1'b1;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        bus.p_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (!ok || bus.y_valid !== 1'b0 || bus.p_ready !== 1'b1) begin
            failures++;
            $display("FAIL clr_abort: got ok=%b v=%b rdy=%b want ok=1 v=0 rdy=1", ok, bus.y_valid, bus.p_ready);
        end
        run_frame(P_HALF, 32'd0, 32'd0, 32'd0, y, s, v, ok);
        checks++;
        if (!ok || v !== 1'b1 || y !== EXP_POS || s !== 1'b0) begin
            failures++;
            $display("FAIL clr_fresh: got %0d sat=%b v=%b want %0d sat=0 v=1", $signed(y), s, v, $signed(EXP_POS));
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] y; logic s; logic v; bit ok; bit k;
        run_frame(P_MAXP, P_MAXP, P_MAXP, P_MAXP, y, s, v, ok);
        for (int i = 0; i < 3; i++) begin
            push(P_MAXP, k);
            ok &= k;
        end
        bus.P = P_MAXP;
        bus.p_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (!ok || {bus.Y, bus.y_sat, bus.y_valid, bus.p_ready} !== 19'h0) begin
            failures++;
            $display("FAIL mid_reset_outputs: got Y=%0d sat=%b v=%b rdy=%b want all 0",
                     $signed(bus.Y), bus.y_sat, bus.y_valid, bus.p_ready);
        end
        @(negedge clk);
        bus.p_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(P_HALF, 32'd0, 32'd0, 32'd0, y, s, v, ok);
        checks++;
        if (!ok || v !== 1'b1 || y !== EXP_POS || s !== 1'b0) begin
            failures++;
            $display("FAIL reset_fresh: got %0d sat=%b v=%b want %0d sat=0 v=1", $signed(y), s, v, $signed(EXP_POS));
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        clr = 1'b0;
        bus.P = 32'd0;
        bus.p_valid = 1'b0;
        bus.y_ready = 1'b0;
        test_reset();
        test_rounding();
        test_saturation();
        test_back_to_back();
        test_clr();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Accumulates a frame of signed 32-bit products from the 16x16 Booth multiplier and emits one rounded, saturated Q15 result per frame. It sits directly downstream of `booth_multiplier`, consuming its `P` output, and forms the MAC back end of the FIR/correlator datapath. Both sides use valid/ready handshakes. The block stalls the multiplier path while a result waits to be taken.

## Interface
- `N_TAPS`, default 8: products per frame, 2..256.
- `ACC_W`, default 40: accumulator width. Must be ≥ 32 + clog2(N_TAPS).
- `OUT_SHIFT`, default 15: right shift applied to the accumulator before saturation. Q30 sums become Q15.
- `clk`  in  1  clock. All state is updated on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous frame abort.
- `P`  in  32  signed product from the multiplier.
- `p_valid`  in  1  `P` is valid this cycle.
- `p_ready`  out  1  block accepts `P`.
- `Y`  out  16  signed saturated result.
- `y_sat`  out  1  `Y` was clipped. Qualified by `y_valid`.
- `y_valid`  out  1  result available.
- `y_ready`  in  1  downstream accepts `Y`.

## Operation
- **States.**
  - ACCUM: `p_ready`=1, `y_valid`=0.
  - OUT: `p_ready`=0, `y_valid`=1.
- **Accept.** A product is accepted when `p_valid && p_ready`.
  - The first accept of a frame (count==0) loads the accumulator with sign-extended `P`. There is no stale add.
  - Later accepts add sign-extended `P` to the accumulator.
  - Each accept increments count.
- **Frame end.** The accept with count==N_TAPS-1 goes to OUT. In the same edge:
  - register `Y` = sat16((acc + P) >>> OUT_SHIFT, with rounding per Configuration);
  - register `y_sat`;
  - reset count to 0.
- **Saturation.** Results above 32767 become 32767; results below -32768 become -32768. `y_sat` is 1 exactly when clipping occurred.
- **Result accept.** In OUT, `y_valid && y_ready` returns to ACCUM. `Y` and `y_sat` hold their last value.
- **Backpressure.** In OUT with `y_ready`=0, `Y` and `y_sat` stay stable and no products are accepted.
- **Clear.** `clr`=1 forces ACCUM, count=0, `y_valid`=0, accumulator=0.
  - `clr` has priority over every simultaneous event, including the N-th accept and a `y_ready` handshake.
  - A product presented in the `clr` cycle is dropped.
- **Reset mid-operation.** All state clears immediately. The partial frame is discarded.
- **Overflow.** Within a frame the accumulator cannot overflow, given the `ACC_W` constraint.

## Timing
- **Reset values:** state=ACCUM, count=0, acc=0, `Y`=0, `y_sat`=0, `y_valid`=0.
- **`p_ready`** is 1 once `rst_n` deasserts. It is a combinational decode of state only and does not depend on `p_valid`.
- **Latency:** `y_valid` rises the cycle after the N-th accept.
- **Throughput:** at best one frame per N_TAPS+1 cycles. The N products arrive back to back, then there is one OUT cycle with `y_ready`=1.
- **Gaps:** bubbles in `p_valid` do not disturb count or acc.
- **Output path:** `Y`, `y_sat` and `y_valid` are registered outputs with no combinational path from inputs.

## Configuration
- **`PRODUCT_ACC_ROUND_EN` defined:** add 2^(OUT_SHIFT-1) before the arithmetic shift (round half up). Saturation is applied after rounding.
- **`PRODUCT_ACC_ROUND_EN` undefined:** arithmetic shift only (truncate toward -inf).

## Test plan
All scenarios use N_TAPS=4, OUT_SHIFT=15.

- **Rounding, positive:** products 16384,0,0,0. Rounding enabled gives `Y`=1; without it `Y`=0. `y_sat`=0 in both cases.
- **Rounding, negative:** products -16384,0,0,0. Rounding enabled gives `Y`=0; without it `Y`=-1.
- **Positive saturation:** four products of 1073741824 (-32768 × -32768) give `Y`=32767, `y_sat`=1.
- **Mixed signs:** products 1073676289 (32767²), 0, 0, 0 give `Y`=32766, `y_sat`=0. Products -1073709056 (-32768 × 32767) ×4 give `Y`=-32768, `y_sat`=1.
- **Backpressure, then back-to-back frame:**
  - Hold `y_ready`=0 for 5 cycles. `Y` stays stable, `p_ready`=0, and `p_valid` is ignored.
  - Raise `y_ready`. The next cycle `p_ready`=1.
  - A second frame of 2400 ×4 gives `Y`=0 (rounding enabled).
- **`clr` and reset mid-frame:**
  - Accept 3 products of 1073741824, then assert `clr` with a 4th product present.
  - No `y_valid` follows. A fresh frame of 16384,0,0,0 yields `Y`=1 (rounding enabled), proving acc was cleared.
  - Repeat the scenario with `rst_n` pulsed low mid-frame. Expect the same result, and all outputs read 0 during reset.
